code_entry_tx: RTL and testbench

Transmit-side sequencer for the keypad code-entry interface consumed by the lock controller.
- Takes a multi-digit code in one handshake.
- Presents the code one 4-bit digit at a time on a nibble bus, each digit qualified by a confirm strobe, with programmable hold and gap timing.
- Used as the stimulus/host end of the lock's `in`/`confirm` port: scripted code entry, board-level self test.

---
 rtl/code_entry_tx_if.sv | 29 ++
 rtl/code_entry_tx.sv | 164 ++++++++++++++++
 tb/tb_code_entry_tx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/code_entry_tx_if.sv
// Code-entry request/response bundle between a host and code_entry_tx.
// Combinational wiring only: zero latency.
// No backpressure: start is only accepted while the sequencer reports idle.
interface code_entry_tx_if #(
    parameter int DIGITS = 2
) ();
    localparam int IW = $clog2(DIGITS + 2);

    logic                  start;
    logic [DIGITS*4-1:0]   code;
    logic                  abort;
    logic [3:0]            in_out;
    logic                  confirm_out;
    logic                  busy;
    logic                  done;
    logic [IW-1:0]         digit_idx;

    // Host side: issues requests and watches the digit stream.
    modport master (
        output start, code, abort,
        input  in_out, confirm_out, busy, done, digit_idx
    );

    // Sequencer side.
    modport slave (
        input  start, code, abort,
        output in_out, confirm_out, busy, done, digit_idx
    );
endinterface

// File: rtl/code_entry_tx.sv
// Keypad code-entry sequencer: sends a captured code one nibble at a time with confirm strobes.
// Latency: first digit and confirm appear at the same edge that samples start (0 cycles).
// Backpressure: none; start is ignored while busy or in DONE. Optional checksum digit: CODE_ENTRY_TX_CHECKSUM_EN.
module code_entry_tx #(
    parameter int DIGITS = 2,
    parameter int HOLD   = 1,
    parameter int GAP    = 2
) (
    input logic            clock,
    input logic            reset,
    code_entry_tx_if.slave bus
);

`ifdef CODE_ENTRY_TX_CHECKSUM_EN
    localparam int NDIG = DIGITS + 1;
`else
    localparam int NDIG = DIGITS;
`endif
    localparam int IW   = $clog2(DIGITS + 2);
    localparam int SW   = NDIG * 4;
    localparam int CMAX = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] HOLD_END = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_END  = (GAP > 0) ? CW'(GAP - 1) : '0;
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  sreg_q,  sreg_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [IW-1:0]  idx_q,   idx_d;

    logic [SW-1:0]  load_val;
    logic           last_digit;
    logic [IW-1:0]  idx_inc;

`ifdef CODE_ENTRY_TX_CHECKSUM_EN
    logic [3:0]     csum;

    // Checksum digit is the XOR of every code nibble, appended after the last one.
    always_comb begin
        csum = '0;
        for (int i = 0; i < DIGITS; i++) begin
            csum = csum ^ bus.code[i*4 +: 4];
        end
    end

    assign load_val = {bus.code, csum};
`else
    assign load_val = bus.code;
`endif

    assign last_digit = (idx_q == LAST_IDX);
    // Index saturates on the last digit so it can never wrap.
    assign idx_inc    = last_digit ? idx_q : idx_q + IW'(1);

    // State, shift register, timing counter and digit index registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: walk each digit through HOLD drive cycles then GAP idle cycles.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_DRIVE;
                    sreg_d  = load_val;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            ST_DRIVE: begin
                if (cnt_q == HOLD_END) begin
                    cnt_d = '0;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                    end else if (last_digit) begin
                        state_d = ST_DONE;
                        sreg_d  = '0;
                        idx_d   = '0;
                    end else begin
                        // Back-to-back digits: present the next one immediately.
                        state_d = ST_DRIVE;
                        sreg_d  = sreg_q << 4;
                        idx_d   = idx_inc;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d = '0;
                    if (last_digit) begin
                        state_d = ST_DONE;
                        sreg_d  = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_DRIVE;
                        sreg_d  = sreg_q << 4;
                        idx_d   = idx_inc;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
                idx_d   = '0;
            end

            default: begin
                state_d = ST_IDLE;
                sreg_d  = '0;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Abort wins over everything, including a start in the same cycle.
        if (bus.abort) begin
            state_d = ST_IDLE;
            sreg_d  = '0;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    // Outputs decode registered state only, so they change exactly at clock edges.
    assign bus.busy        = (state_q == ST_DRIVE) || (state_q == ST_GAP);
    assign bus.confirm_out = (state_q == ST_DRIVE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.in_out      = bus.busy ? sreg_q[SW-1 -: 4] : 4'h0;
    assign bus.digit_idx   = idx_q;

endmodule

// File: tb/tb_code_entry_tx.sv
module tb_code_entry_tx;

    typedef struct packed {
        logic [3:0] d;
        logic       c;
        logic       b;
        logic       dn;
        logic [1:0] idx;
    } obs_t;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    obs_t sb[$];
    obs_t obs_a, obs_b;

    always #5 clock = ~clock;

    code_entry_tx_if #(.DIGITS(2)) if_a ();
    code_entry_tx_if #(.DIGITS(2)) if_b ();

    code_entry_tx #(.DIGITS(2), .HOLD(1), .GAP(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (if_a.slave)
    );

    code_entry_tx #(.DIGITS(2), .HOLD(2), .GAP(0)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (if_b.slave)
    );

    assign obs_a = {if_a.in_out, if_a.confirm_out, if_a.busy, if_a.done, if_a.digit_idx};
    assign obs_b = {if_b.in_out, if_b.confirm_out, if_b.busy, if_b.done, if_b.digit_idx};

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic c, input logic b,
                        input logic dn, input logic [1:0] idx);
        obs_t e;
        e = {d, c, b, dn, idx};
        sb.push_back(e);
    endtask

    task automatic push_idle();
        push(4'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    // Reference cycle sequence for one complete transfer of an 8-bit code.
    task automatic push_xfer(input logic [7:0] code, input int hold, input int gap);
        logic [3:0] dig [3];
        int         n;
        dig[0] = code[7:4];
        dig[1] = code[3:0];
        dig[2] = code[7:4] ^ code[3:0];
        n = 2;
`ifdef CODE_ENTRY_TX_CHECKSUM_EN
        n = 3;
`endif
        for (int i = 0; i < n; i++) begin
            for (int h = 0; h < hold; h++) push(dig[i], 1'b1, 1'b1, 1'b0, 2'(i));
            for (int g = 0; g < gap; g++)  push(dig[i], 1'b0, 1'b1, 1'b0, 2'(i));
        end
        push(4'h0, 1'b0, 1'b0, 1'b1, 2'd0);
    endtask

    task automatic check(input int sel, input string tag);
        obs_t e, o;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            o = (sel != 0) ? obs_b : obs_a;
            assert (o === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, o, e);
            end
        end
    endtask

    task automatic drain(input int sel, input string tag);
        while (sb.size() > 0) begin
            step();
            check(sel, tag);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with start asserted: nothing may move.
        reset       = 1'b0;
        if_a.start  = 1'b1;
        if_a.code   = 8'hFA;
        if_a.abort  = 1'b0;
        if_b.start  = 1'b1;
        if_b.code   = 8'hFA;
        if_b.abort  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            push_idle(); check(0, "reset_hold_a");
            push_idle(); check(1, "reset_hold_b");
        end
        reset      = 1'b1;
        if_a.start = 1'b0;
        if_b.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            push_idle(); check(0, "post_reset_idle");
        end

        // Nominal transfer, HOLD=1 GAP=2.
        if_a.code  = 8'hFA;
        if_a.start = 1'b1;
        push_xfer(8'hFA, 1, 2);
        step(); check(0, "nominal_first");
        if_a.start = 1'b0;
        drain(0, "nominal");
        push_idle(); step(); check(0, "nominal_after");

        // Back-to-back digits, HOLD=2 GAP=0.
        if_b.code  = 8'hB6;
        if_b.start = 1'b1;
        push_xfer(8'hB6, 2, 0);
        step(); check(1, "nogap_first");
        if_b.start = 1'b0;
        drain(1, "nogap");
        push_idle(); step(); check(1, "nogap_after");

        // Abort while the second digit is being confirmed.
        if_a.code  = 8'h1F;
        if_a.start = 1'b1;
        push(4'h1, 1'b1, 1'b1, 1'b0, 2'd0);
        push(4'h1, 1'b0, 1'b1, 1'b0, 2'd0);
        push(4'h1, 1'b0, 1'b1, 1'b0, 2'd0);
        push(4'hF, 1'b1, 1'b1, 1'b0, 2'd1);
        step(); check(0, "abort_pre");
        if_a.start = 1'b0;
        drain(0, "abort_pre");
        if_a.abort = 1'b1;
        push_idle(); step(); check(0, "abort_clear");
        if_a.abort = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_idle(); step(); check(0, "abort_no_done");
        end

        // Abort beats start in the same cycle.
        if_a.start = 1'b1;
        if_a.abort = 1'b1;
        push_idle(); step(); check(0, "abort_priority");
        if_a.start = 1'b0;
        if_a.abort = 1'b0;

        // Start held high throughout; code changed mid-transfer must not matter.
        if_a.code  = 8'hFA;
        if_a.start = 1'b1;
        push_xfer(8'hFA, 1, 2);
        push_idle();
        push_xfer(8'h00, 1, 2);
        step(); check(0, "held_first");
        if_a.code = 8'h00;
        drain(0, "held_start");
        if_a.start = 1'b0;
        push_idle(); step(); check(0, "held_after");

        // Asynchronous reset mid-transfer acts immediately, no leftover pulse.
        if_a.code  = 8'h3C;
        if_a.start = 1'b1;
        push(4'h3, 1'b1, 1'b1, 1'b0, 2'd0);
        step(); check(0, "arst_pre");
        if_a.start = 1'b0;
        push(4'h3, 1'b0, 1'b1, 1'b0, 2'd0);
        step(); check(0, "arst_pre");
        #2;
        reset = 1'b0;
        #1;
        push_idle(); check(0, "arst_immediate");
        step();
        push_idle(); check(0, "arst_held");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_idle(); step(); check(0, "arst_release");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
